// File: rtl/pipeline_skid_buffer.sv
// Two-entry elastic pipeline stage (main + skid) with valid/ready handshake and flush.
// All state changes on the falling clock edge; outputs decode registered state only.
module pipeline_skid_buffer #(
    parameter int NUM_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] din,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] dout,
    output logic [1:0]          occupancy
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [NUM_BITS-1:0] main_q, main_d;
    logic [NUM_BITS-1:0] skid_q, skid_d;
    logic                in_fire, out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign dout      = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        case (state_q)
            BUSY:    occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = din;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && !out_fire) begin
                    skid_d  = din;
                    state_d = FULL;
                end else if (in_fire && out_fire) begin
                    main_d  = din;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain path exists
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            // data registers keep stale contents; only occupancy is killed
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
